riscv_trace_buffer: RTL and testbench
=====================================

# riscv_trace_buffer

On-chip, synthesizable execution-trace capture for the RISC-V 32-bit core. Sits beside `RISCV` and taps the same debug nets the top-level bench monitors (`pc_out`, `instruction`, `alu_result`). It records them into a parametrised circular buffer, arms and triggers on a programmable PC match, and freezes after a configurable post-trigger window. A host or bench then reads the trace out oldest-first, with no simulator `$monitor` and no fixed run time.

## Interface
- `XLEN`, 32: width of PC, instruction and ALU result fields.
- `DEPTH`, 16: entries in the buffer. Must be a power of two, ≥4.
- `POST_TRIG`, 8: entries captured after the trigger entry. Must satisfy 0 ≤ POST_TRIG ≤ DEPTH-1.
- `AW`, $clog2(DEPTH): derived pointer width. Do not override.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `arm`  in  1  single-cycle pulse; clears the trace and starts capture.
- `trig_en`  in  1  enables the PC-match trigger.
- `trig_pc`  in  XLEN  PC value that fires the trigger.
- `cap_valid`  in  1  core retired an instruction this cycle; capture strobe.
- `pc_out`  in  XLEN  core PC.
- `instruction`  in  XLEN  core instruction word.
- `alu_result`  in  XLEN  core ALU result.
- `rd_en`  in  1  readout request.
- `rd_addr`  in  AW  logical index; 0 = oldest valid entry.
- `rd_data`  out  3*XLEN  {pc, instruction, alu_result} of the addressed entry.
- `rd_valid`  out  1  `rd_data` valid; one-cycle pulse.
- `state`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- `count`  out  AW+1  valid entries held; saturates at DEPTH.
- `trig_index`  out  AW  logical index of the trigger entry; meaningful in POST/DONE only.
- `done`  out  1  high while in DONE.

## Operation
- State machine:
  - IDLE: no capture.
  - `arm` moves any state to ARMED. On entry, `count`, the write pointer and the post counter are cleared.
  - ARMED: every `cap_valid` cycle writes one entry at `wr_ptr`, then `wr_ptr` increments mod DEPTH and `count` increments, saturating at DEPTH. Oldest entries are overwritten.
  - Trigger is `cap_valid && trig_en && pc_out == trig_pc` while in ARMED. The trigger entry itself is written. `trig_index` is latched as `count` after that write minus 1, saturating at DEPTH-1. Next state is POST, or DONE if POST_TRIG = 0.
  - POST: each `cap_valid` writes an entry and increments the post counter. The PC match is ignored. Once POST_TRIG entries are written, the next state is DONE. While in POST, `trig_index` decrements each time an overwrite occurs with `count` = DEPTH, and holds at 0.
  - DONE: no writes. Buffer, `count` and `trig_index` are frozen until `arm` or `reset`.
- Readout:
  - Allowed in any state.
  - Physical address = (wr_ptr − count + rd_addr) mod DEPTH.
  - If `rd_addr` ≥ `count`, `rd_data` = 0 and `rd_valid` still pulses.
- Simultaneous events:
  - `arm` in the same cycle as a trigger or `cap_valid`: `arm` wins. Nothing is written that cycle.
  - `rd_en` in the same cycle as a write: the read returns pre-write contents and pointers.
- Reset:
  - `state` = IDLE; `count`, `trig_index`, `rd_data`, `rd_valid`, `done` = 0; internal pointers = 0.
  - Buffer RAM is not cleared. Stale entries are unreachable because `count` = 0.
  - Reset mid-capture discards the trace; `arm` is required to restart.

## Timing
- Capture: an entry presented with `cap_valid` in cycle N is readable from cycle N+1.
- Read latency is 1 cycle. `rd_en`/`rd_addr` sampled in cycle N give `rd_data`/`rd_valid` in N+1. Back-to-back reads give one result per cycle.
- `state`, `count`, `done` and `trig_index` are registered. They update on the edge that performs the write or transition.
- The trigger compare is combinational on current inputs. No extra latency.

## Configuration
- `TRACE_TIMESTAMP_EN` defined:
  - A 32-bit free-running cycle counter is added. It is cleared by `reset` and by `arm`, and increments every cycle while not IDLE and not DONE.
  - Each entry also stores the counter value at capture.
  - An extra output `rd_stamp` (out, 32) appears with the same 1-cycle latency as `rd_data`. It returns 0 for out-of-range reads.
- `TRACE_TIMESTAMP_EN` undefined: no counter, no stamp storage, no `rd_stamp` port. All other behaviour is identical.

## Test plan
- Reset, then 5 `cap_valid` cycles without `arm` → `count`=0, `state`=IDLE. Any read gives `rd_data`=0 with `rd_valid`=1 one cycle later.
- `arm`, then 20 captures with PC = 0,4,…,76, `trig_en`=0, DEPTH=16 → `count`=16. `rd_addr`=0 returns pc 0x10; `rd_addr`=15 returns pc 0x4C.
- `arm`, `trig_pc`=0x20, PC stepping by 4 from 0, POST_TRIG=8 → DONE after pc 0x40 is written. `count`=17 saturates to 16, `trig_index`=7, further `cap_valid` ignored.
- `cap_valid` gaps of 3 idle cycles between retirements → only strobed entries are stored. With the macro on, `rd_stamp` deltas between adjacent entries equal 4.
- `arm` asserted in the same cycle as a matching PC → no entry written, `state`=ARMED, `count`=0.
- `reset` asserted during POST → next cycle `state`=IDLE, `count`=0, `done`=0. A subsequent `arm` and trigger sequence behaves as in scenario 3.

Source files
------------

// File: rtl/riscv_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : riscv_trace_buffer
// Brief    : PC-triggered circular execution-trace buffer with oldest-first
//            readout. Optional macro TRACE_TIMESTAMP_EN adds per-entry stamps.
// Revision : 1.0
// ============================================================================
module riscv_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [XLEN-1:0]   trig_pc,
  input  logic              cap_valid,
  input  logic [XLEN-1:0]   pc_out,
  input  logic [XLEN-1:0]   instruction,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [3*XLEN-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic [AW:0]       count,
  output logic [AW-1:0]     trig_index,
  output logic              done
`ifdef TRACE_TIMESTAMP_EN
  ,output logic [31:0]      rd_stamp
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [AW:0]   C_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_POST_TRIG = (AW+1)'(POST_TRIG);
  localparam logic [AW:0]   C_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [AW:0]         post_q, post_d;
  logic [AW-1:0]       trig_idx_q, trig_idx_d;
  logic [3*XLEN-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                wr_en;
  logic [AW:0]         count_inc;
  logic [AW-1:0]       rd_phys;
  logic                rd_in_range;

  logic [3*XLEN-1:0]   mem_q [DEPTH];

  assign count_inc   = (count_q == C_DEPTH) ? count_q : count_q + C_CNT_ONE;
  assign rd_phys     = wr_ptr_q - AW'(count_q) + rd_addr;
  assign rd_in_range = ({1'b0, rd_addr} < count_q);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    trig_idx_d = trig_idx_q;
    wr_en      = 1'b0;
    if (arm) begin
      // arm takes priority over any capture or trigger in the same cycle
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      count_d    = '0;
      post_d     = '0;
      trig_idx_d = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (cap_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            count_d  = count_inc;
            if (trig_en && (pc_out == trig_pc)) begin
              trig_idx_d = AW'(count_inc - C_CNT_ONE);
              state_d    = (POST_TRIG == 0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (cap_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            count_d  = count_inc;
            post_d   = post_q + C_CNT_ONE;
            // a full-buffer write evicts the oldest entry, so the trigger slides toward 0
            if ((count_q == C_DEPTH) && (trig_idx_q != '0)) begin
              trig_idx_d = trig_idx_q - C_PTR_ONE;
            end
            if (post_d == C_POST_TRIG) begin
              state_d = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      trig_idx_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      trig_idx_q <= trig_idx_d;
      rd_valid_q <= rd_en;
      rd_data_q  <= (rd_en && rd_in_range) ? mem_q[rd_phys] : '0;
    end
  end

  // Trace RAM is deliberately not reset; count = 0 hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {pc_out, instruction, alu_result};
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] rd_stamp_q;
  logic [31:0] stamp_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || arm) begin
      ts_q <= '0;
    end else if ((state_q == S_ARMED) || (state_q == S_POST)) begin
      ts_q <= ts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      stamp_mem_q[wr_ptr_q] <= ts_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_stamp_q <= '0;
    end else begin
      rd_stamp_q <= (rd_en && rd_in_range) ? stamp_mem_q[rd_phys] : '0;
    end
  end

  assign rd_stamp = rd_stamp_q;
`endif

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign state      = state_q;
  assign count      = count_q;
  assign trig_index = trig_idx_q;
  assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_riscv_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_trace_buffer
// Brief    : Directed bench for riscv_trace_buffer with a read-data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_riscv_trace_buffer;

  localparam int XLEN = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm;
  logic              trig_en;
  logic [XLEN-1:0]   trig_pc;
  logic              cap_valid;
  logic [XLEN-1:0]   pc_out;
  logic [XLEN-1:0]   instruction;
  logic [XLEN-1:0]   alu_result;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [3*XLEN-1:0] rd_data;
  logic              rd_valid;
  logic [1:0]        state;
  logic [AW:0]       count;
  logic [AW-1:0]     trig_index;
  logic              done;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]       rd_stamp;
`endif

  int total = 0;
  int bad   = 0;

  logic [3*XLEN-1:0] exp_data_q [$];
  logic [31:0]       exp_stamp_q [$];
  bit                exp_chk_q [$];
  string             exp_name_q [$];

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .trig_en     (trig_en),
    .trig_pc     (trig_pc),
    .cap_valid   (cap_valid),
    .pc_out      (pc_out),
    .instruction (instruction),
    .alu_result  (alu_result),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .state       (state),
    .count       (count),
    .trig_index  (trig_index),
    .done        (done)
`ifdef TRACE_TIMESTAMP_EN
    ,.rd_stamp   (rd_stamp)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3*XLEN-1:0] ent(input logic [31:0] pc);
    return {pc, {16'hC0DE, pc[15:0]}, pc + 32'h1000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [3*XLEN-1:0] d,
                          input logic [31:0] st, input bit chk_st);
    exp_data_q.push_back(d);
    exp_stamp_q.push_back(st);
    exp_chk_q.push_back(chk_st);
    exp_name_q.push_back(name);
  endtask

  task automatic cap(input logic [31:0] pc);
    cap_valid   = 1'b1;
    pc_out      = pc;
    instruction = {16'hC0DE, pc[15:0]};
    alu_result  = pc + 32'h1000;
    tick();
    cap_valid   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [AW-1:0] a,
                    input logic [3*XLEN-1:0] d, input logic [31:0] st, input bit chk_st);
    rd_en   = 1'b1;
    rd_addr = a;
    push_exp(name, d, st, chk_st);
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_data_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (exp_data_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_data_q.size());
      exp_data_q.delete();
      exp_stamp_q.delete();
      exp_chk_q.delete();
      exp_name_q.delete();
    end
  endtask

  // Monitor: every rd_valid pulse is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      total++;
      if (exp_data_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rd_valid: got rd_data 0x%0h with nothing expected", rd_data);
      end else begin
        logic [3*XLEN-1:0] d;
        logic [31:0]       st;
        bit                c;
        string             nm;
        d  = exp_data_q.pop_front();
        st = exp_stamp_q.pop_front();
        c  = exp_chk_q.pop_front();
        nm = exp_name_q.pop_front();
        if (rd_data !== d) begin
          bad++;
          $display("FAIL %s: rd_data 0x%0h expected 0x%0h", nm, rd_data, d);
        end
`ifdef TRACE_TIMESTAMP_EN
        if (c) begin
          total++;
          if (rd_stamp !== st) begin
            bad++;
            $display("FAIL %s_stamp: rd_stamp %0d expected %0d", nm, rd_stamp, st);
          end
        end
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; cap_valid = 1'b0;
    pc_out = '0; instruction = '0; alu_result = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state, then captures while IDLE are ignored
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trig_index", 32'(trig_index), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 5; i++) cap(32'(i * 4));
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_state", 32'(state), 32'd0);
    rd("idle_rd", 4'd3, '0, 32'd0, 1'b1);
    drain();

    // Wrap-around without trigger
    do_arm();
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_count", 32'(count), 32'd0);
    for (int i = 0; i < 20; i++) cap(32'(i * 4));
    chk("wrap_count", 32'(count), 32'd16);
    chk("wrap_state", 32'(state), 32'd1);
    rd("wrap_rd0", 4'd0, ent(32'h10), 32'd0, 1'b0);
    rd("wrap_rd15", 4'd15, ent(32'h4C), 32'd0, 1'b0);
    rd("wrap_rd5", 4'd5, ent(32'h24), 32'd0, 1'b0);
    drain();

    // Trigger at 0x20, eight post entries, then freeze
    do_arm();
    trig_en = 1'b1;
    trig_pc = 32'h20;
    for (int i = 0; i <= 8; i++) cap(32'(i * 4));
    chk("trig_state", 32'(state), 32'd2);
    chk("trig_count", 32'(count), 32'd9);
    chk("trig_index_at_trig", 32'(trig_index), 32'd8);
    for (int i = 9; i <= 16; i++) cap(32'(i * 4));
    chk("post_state", 32'(state), 32'd3);
    chk("post_done", 32'(done), 32'd1);
    chk("post_count", 32'(count), 32'd16);
    chk("post_trig_index", 32'(trig_index), 32'd7);
    cap(32'h44);
    cap(32'h20);
    chk("frozen_count", 32'(count), 32'd16);
    chk("frozen_trig_index", 32'(trig_index), 32'd7);
    rd("done_rd0", 4'd0, ent(32'h04), 32'd0, 1'b0);
    rd("done_rd15", 4'd15, ent(32'h40), 32'd0, 1'b0);
    rd("done_rd_trig", 4'd7, ent(32'h20), 32'd0, 1'b0);
    drain();

    // Sparse retirements: only strobed cycles are stored, stamps step by 4
    trig_en = 1'b0;
    do_arm();
    cap(32'h100);
    repeat (3) tick();
    cap(32'h104);
    repeat (3) tick();
    cap(32'h108);
    chk("gap_count", 32'(count), 32'd3);
    rd("gap_rd0", 4'd0, ent(32'h100), 32'd0, 1'b1);
    rd("gap_rd1", 4'd1, ent(32'h104), 32'd4, 1'b1);
    rd("gap_rd2", 4'd2, ent(32'h108), 32'd8, 1'b1);
    drain();

    // Read colliding with a write sees pre-write count
    rd_en = 1'b1; rd_addr = 4'd3;
    push_exp("rw_collide", '0, 32'd0, 1'b1);
    cap(32'h10C);
    rd_en = 1'b0;
    chk("rw_count", 32'(count), 32'd4);
    rd("rw_after", 4'd3, ent(32'h10C), 32'd0, 1'b0);
    drain();

    // arm coincident with a matching capture writes nothing
    arm = 1'b1; trig_en = 1'b1; trig_pc = 32'h50;
    cap(32'h50);
    arm = 1'b0;
    chk("armcol_state", 32'(state), 32'd1);
    chk("armcol_count", 32'(count), 32'd0);
    rd("armcol_rd", 4'd0, '0, 32'd0, 1'b1);
    drain();

    // Reset in POST, then a full trigger sequence again
    trig_pc = 32'h20;
    for (int i = 0; i <= 10; i++) cap(32'(i * 4));
    chk("pre_rst_state", 32'(state), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    do_arm();
    for (int i = 0; i <= 16; i++) cap(32'(i * 4));
    chk("rerun_done", 32'(done), 32'd1);
    chk("rerun_count", 32'(count), 32'd16);
    chk("rerun_trig_index", 32'(trig_index), 32'd7);
    rd("rerun_rd_trig", 4'd7, ent(32'h20), 32'd0, 1'b0);
    drain();

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
